// File: rtl/satcom_pkg.sv
// Shared types and constants for the satcom receive path (serial deframer and
// its majority-vote helper).
package satcom_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int   BAUD_1200_OVERSAMPLE = 16;
  localparam int   SAMPLE_MID           = BAUD_1200_OVERSAMPLE / 2;
  localparam logic IDLE_LEVEL           = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_serial_deframer_if.sv
// Byte-side interface of the serial deframer: valid/ready data plus status pulses.
// parity_err only exists when RX_PARITY_EN is defined.
interface rx_serial_deframer_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

`ifdef RX_PARITY_EN
  logic                 parity_err;

  modport master (
    output rx_data, rx_valid, frame_err, overrun, busy, parity_err,
    input  rx_ready
  );
  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, busy, parity_err,
    output rx_ready
  );
`else
  modport master (
    output rx_data, rx_valid, frame_err, overrun, busy,
    input  rx_ready
  );
  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, busy,
    output rx_ready
  );
`endif

endinterface

// File: rtl/rx_majority3.sv
// 2-of-3 vote over the last two stored samples plus the current one, so the
// decision is available on the third sample tick itself.
module rx_majority3
  import satcom_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic sample_i,
  input  logic din_i,
  output logic vote_o
);

  logic [1:0] hist_q;
  logic [1:0] hist_d;

  assign hist_d = {hist_q[0], din_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        hist_q <= {2{IDLE_LEVEL}};
    else if (sample_i) hist_q <= hist_d;
  end

  assign vote_o = maj3(hist_q[1], hist_q[0], din_i);

endmodule

// File: rtl/rx_serial_deframer.sv
// Oversampling async-serial deframer: start + DATA_BITS (LSB first) + stop,
// optional parity bit when RX_PARITY_EN is defined.
module rx_serial_deframer
  import satcom_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = BAUD_1200_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic master_clk,
  input  logic reset_n,
  input  logic sample_tick,
  input  logic rx_serial,
  rx_serial_deframer_if.master bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int M  = OVERSAMPLE / 2;

  localparam logic [CW-1:0] CNT_FIRST = CW'(M - 1);
  localparam logic [CW-1:0] CNT_DEC   = CW'(M + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  rx_state_e              state_q;
  logic [CW-1:0]          cnt_q;
  logic [BW-1:0]          bit_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   armed_q;
  logic                   rx_valid_q;
  logic                   frame_err_q;
  logic                   overrun_q;
  logic                   busy_q;
  logic                   sample_en;
  logic                   decide;
  logic                   wrap;
  logic                   vote;
`ifdef RX_PARITY_EN
  logic                   par_q;
  logic                   parity_err_q;
`endif

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign sample_en = sample_tick && (state_q != IDLE) && (cnt_q >= CNT_FIRST) && (cnt_q <= CNT_DEC);
  assign decide    = sample_tick && (state_q != IDLE) && (cnt_q == CNT_DEC);
  assign wrap      = sample_tick && (cnt_q == CNT_LAST);

  rx_majority3 u_maj (
    .clk      (master_clk),
    .rst_n    (reset_n),
    .sample_i (sample_en),
    .din_i    (rx_s),
    .vote_o   (vote)
  );

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], rx_serial};
  end

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      armed_q     <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (rx_valid_q && bus.rx_ready) rx_valid_q <= 1'b0;

      if (sample_tick) begin
        if (state_q != IDLE) cnt_q <= cnt_q + CW'(1);
        case (state_q)
          // A start is only accepted once the line has been seen idle since reset.
          IDLE: begin
            if (rx_s == IDLE_LEVEL) armed_q <= 1'b1;
            else if (armed_q) begin
              state_q <= START;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          START: begin
            if (decide && vote) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
            end else if (wrap) begin
              state_q <= DATA;
              bit_q   <= '0;
            end
          end
          DATA: begin
            if (decide) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
            if (wrap) begin
              if (bit_q == BIT_LAST) begin
                bit_q   <= '0;
`ifdef RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end else begin
                bit_q <= bit_q + BW'(1);
              end
            end
          end
`ifdef RX_PARITY_EN
          PARITY: begin
            if (decide) par_q   <= vote;
            if (wrap)   state_q <= STOP;
          end
`endif
          // Leave at mid-stop so the next start edge is never missed.
          STOP: begin
            if (decide) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              if (vote) begin
                if (!rx_valid_q || bus.rx_ready) begin
                  rx_data_q  <= shift_q;
                  rx_valid_q <= 1'b1;
                end else begin
                  overrun_q  <= 1'b1;
                end
`ifdef RX_PARITY_EN
                parity_err_q <= ^{shift_q, par_q};
`endif
              end else begin
                frame_err_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = busy_q;
`ifdef RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule
